// File: rtl/imm_gen_stage.sv
// imm_gen_stage
// Immediate-generation pipeline stage. The immediate is extracted
// combinationally from the incoming instruction word. It is then registered
// together with the instruction in a two-entry skid buffer, which has a main
// (output) register and one skid register.
// in_ready is a pure register, so out_ready has no combinational path to
// in_ready. XLEN may be 32 or 64.

module imm_gen_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm
);

    // Immediate format selects
    localparam logic [2:0] SEL_I  = 3'b000;
    localparam logic [2:0] SEL_S  = 3'b001;
    localparam logic [2:0] SEL_B  = 3'b010;
    localparam logic [2:0] SEL_J  = 3'b011;
    localparam logic [2:0] SEL_U  = 3'b100;
    localparam logic [2:0] SEL_Z  = 3'b101;
    localparam logic [2:0] SEL_SH = 3'b110;

    // Every format fits in 32 bits once it is sign- or zero-extended to 32
    // bits. The 32-bit value is then widened by a signed cast, so bit 31
    // carries the sign (or zero) up to XLEN. This needs no zero-width
    // replication when XLEN is 32.
    function automatic logic [XLEN-1:0] decode_imm(
        input logic [31:0] instr,
        input logic [2:0]  sel
    );
        logic [31:0] raw32;
        case (sel)
            SEL_I:   raw32 = {{20{instr[31]}}, instr[31:20]};
            SEL_S:   raw32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SEL_B:   raw32 = {{20{instr[31]}}, instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            SEL_J:   raw32 = {{12{instr[31]}}, instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            SEL_U:   raw32 = {instr[31:12], 12'b0};
            SEL_Z:   raw32 = {27'b0, instr[19:15]};
            SEL_SH: begin
                if (XLEN == 64) begin
                    raw32 = {26'b0, instr[25:20]};
                end else begin
                    raw32 = {27'b0, instr[24:20]};
                end
            end
            default: raw32 = 32'b0;
        endcase
        return XLEN'($signed(raw32));
    endfunction

    // Held state
    logic            main_valid_r;
    logic [31:0]     main_instr_r;
    logic [XLEN-1:0] main_imm_r;
    logic            skid_valid_r;
    logic [31:0]     skid_instr_r;
    logic [XLEN-1:0] skid_imm_r;
    logic            in_ready_r;

    // Next-state values
    logic            main_valid_s;
    logic [31:0]     main_instr_s;
    logic [XLEN-1:0] main_imm_s;
    logic            skid_valid_s;
    logic [31:0]     skid_instr_s;
    logic [XLEN-1:0] skid_imm_s;
    logic            in_ready_s;

    // Handshake events and the decoded immediate of the incoming word
    logic            accept_s;
    logic            drain_s;
    logic [XLEN-1:0] in_imm_s;

    // Decode the immediate and qualify the two transfer events
    always_comb begin
        in_imm_s = decode_imm(in_instr, in_imm_sel);
        accept_s = in_valid & in_ready_r;
        drain_s  = main_valid_r & out_ready;
    end

    // Next-state logic for the main and skid entries; flush takes priority
    always_comb begin
        main_valid_s = main_valid_r;
        main_instr_s = main_instr_r;
        main_imm_s   = main_imm_r;
        skid_valid_s = skid_valid_r;
        skid_instr_s = skid_instr_r;
        skid_imm_s   = skid_imm_r;

        if (flush) begin
            // Discard both entries and any word offered this cycle
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (drain_s || !main_valid_r) begin
            // Main is free at this edge: the oldest pending entry fills it
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_instr_s = skid_instr_r;
                main_imm_s   = skid_imm_r;
                skid_valid_s = 1'b0;
            end else if (accept_s) begin
                main_valid_s = 1'b1;
                main_instr_s = in_instr;
                main_imm_s   = in_imm_s;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            // Main is stalled: an accepted word parks in the skid register
            if (accept_s) begin
                skid_valid_s = 1'b1;
                skid_instr_s = in_instr;
                skid_imm_s   = in_imm_s;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end

        in_ready_s = ~skid_valid_s;
    end

    // State registers; reset clears every entry and opens the input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_instr_r <= 32'b0;
            main_imm_r   <= {XLEN{1'b0}};
            skid_valid_r <= 1'b0;
            skid_instr_r <= 32'b0;
            skid_imm_r   <= {XLEN{1'b0}};
            in_ready_r   <= 1'b1;
        end else begin
            main_valid_r <= main_valid_s;
            main_instr_r <= main_instr_s;
            main_imm_r   <= main_imm_s;
            skid_valid_r <= skid_valid_s;
            skid_instr_r <= skid_instr_s;
            skid_imm_r   <= skid_imm_s;
            in_ready_r   <= in_ready_s;
        end
    end

    // Outputs come straight from registers
    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_instr = main_instr_r;
    assign out_imm   = main_imm_r;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage
// Drives identical traffic into an XLEN=64 and an XLEN=32 instance.
// Expected values come from a queue-based FIFO model and an arithmetic
// immediate reference.

module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_sel;

    logic        rdy64, ov64, rdy32, ov32;
    logic [31:0] oi64, oi32;
    logic [63:0] om64;
    logic [31:0] om32;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_imm_sel(in_imm_sel),
        .out_valid(ov64), .out_ready(out_ready),
        .out_instr(oi64), .out_imm(om64)
    );

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_imm_sel(in_imm_sel),
        .out_valid(ov32), .out_ready(out_ready),
        .out_instr(oi32), .out_imm(om32)
    );

    // Interpret the low 'bits' of v as a two's-complement number
    function automatic longint sx(input longint v, input int bits);
        longint half;
        half = longint'(1) <<< (bits - 1);
        if (v >= half) return v - (half * 2);
        else return v;
    endfunction

    // Immediate value computed arithmetically from the field weights
    function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] s,
                                            input int xlen);
        longint v;
        case (s)
            3'd0: v = sx(longint'(i[31:20]), 12);
            3'd1: v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            3'd2: v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                         + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            3'd3: v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                         + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            3'd4: v = sx(longint'(i[31:12]) * 4096, 32);
            3'd5: v = longint'(i[19:15]);
            3'd6: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    // One clock: drive inputs, advance, update the FIFO model
    task automatic cycle(input logic iv, input logic [31:0] ins,
                         input logic [2:0] sel, input logic ordy,
                         input logic fl);
        bit   acc, drn;
        ent_t e;
        in_valid = iv; in_instr = ins; in_imm_sel = sel;
        out_ready = ordy; flush = fl;
        acc = iv && (mq.size() < 2);
        drn = ordy && (mq.size() > 0);
        @(posedge clk); #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                e.instr = ins; e.sel = sel;
                mq.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (ov64 !== 1'b0 || ov32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b/%b want 0", ov64, ov32); end
        n_cmp++; if (rdy64 !== 1'b1 || rdy32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1", rdy64, rdy32); end
        n_cmp++; if (om64 !== 64'h0 || om32 !== 32'h0 || oi64 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", om64, om32, oi64); end
        reset = 1'b0;
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        n_cmp++; if (ov64 !== 1'b0 || rdy64 !== 1'b1) begin n_fail++; $display("FAIL post_reset: got valid=%b ready=%b want 0/1", ov64, rdy64); end
    endtask

    task automatic test_formats();
        logic [31:0] f_instr [4];
        logic [2:0]  f_sel   [4];
        logic [63:0] f_exp   [4];
        f_instr = '{32'hFFF00093, 32'hFE20AE23, 32'h800000B7, 32'h300FD073};
        f_sel   = '{3'd0, 3'd1, 3'd4, 3'd5};
        f_exp   = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                    64'hFFFFFFFF80000000, 64'h000000000000001F};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, f_instr[k], f_sel[k], 1'b1, 1'b0);
            n_cmp++; if (ov64 !== 1'b1 || oi64 !== f_instr[k]) begin n_fail++; $display("FAIL fmt_instr[%0d]: got v=%b %h want 1 %h", k, ov64, oi64, f_instr[k]); end
            n_cmp++; if (om64 !== f_exp[k]) begin n_fail++; $display("FAIL fmt_imm[%0d]: got %h want %h", k, om64, f_exp[k]); end
        end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_xlen32();
        cycle(1'b1, 32'h800000B7, 3'd4, 1'b1, 1'b0);
        n_cmp++; if (om32 !== 32'h80000000) begin n_fail++; $display("FAIL x32_u: got %h want 80000000", om32); end
        n_cmp++; if (om64 !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL x64_u: got %h want ffffffff80000000", om64); end
        cycle(1'b1, 32'h02F00013, 3'd6, 1'b1, 1'b0);
        n_cmp++; if (om32 !== 32'h0000000F) begin n_fail++; $display("FAIL x32_sh: got %h want 0000000f", om32); end
        n_cmp++; if (om64 !== 64'h000000000000002F) begin n_fail++; $display("FAIL x64_sh: got %h want 2f", om64); end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c;
        a = $urandom(); b = $urandom(); c = $urandom();
        cycle(1'b1, a, 3'd0, 1'b0, 1'b0);
        n_cmp++; if (ov64 !== 1'b1 || oi64 !== a || rdy64 !== 1'b1) begin n_fail++; $display("FAIL bp_a: got v=%b %h rdy=%b want 1 %h 1", ov64, oi64, rdy64, a); end
        cycle(1'b1, b, 3'd1, 1'b0, 1'b0);
        n_cmp++; if (oi64 !== a || rdy64 !== 1'b0 || rdy32 !== 1'b0) begin n_fail++; $display("FAIL bp_b: got %h rdy=%b want %h 0", oi64, rdy64, a); end
        cycle(1'b1, c, 3'd2, 1'b0, 1'b0);
        n_cmp++; if (oi64 !== a || rdy64 !== 1'b0) begin n_fail++; $display("FAIL bp_c_held: got %h rdy=%b want %h 0", oi64, rdy64, a); end
        cycle(1'b1, c, 3'd2, 1'b1, 1'b0);
        n_cmp++; if (ov64 !== 1'b1 || oi64 !== b || rdy64 !== 1'b1) begin n_fail++; $display("FAIL bp_out_b: got v=%b %h rdy=%b want 1 %h 1", ov64, oi64, rdy64, b); end
        cycle(1'b1, c, 3'd2, 1'b1, 1'b0);
        n_cmp++; if (ov64 !== 1'b1 || oi64 !== c) begin n_fail++; $display("FAIL bp_out_c: got v=%b %h want 1 %h", ov64, oi64, c); end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        n_cmp++; if (ov64 !== 1'b0 || ov32 !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b/%b want 0", ov64, ov32); end
    endtask

    task automatic test_flush();
        cycle(1'b1, $urandom(), 3'd0, 1'b0, 1'b0);
        cycle(1'b1, $urandom(), 3'd0, 1'b0, 1'b0);
        n_cmp++; if (rdy64 !== 1'b0 || ov64 !== 1'b1) begin n_fail++; $display("FAIL flush_full: got rdy=%b v=%b want 0 1", rdy64, ov64); end
        cycle(1'b1, $urandom(), 3'd1, 1'b1, 1'b1);
        n_cmp++; if (ov64 !== 1'b0 || rdy64 !== 1'b1 || ov32 !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got v=%b rdy=%b want 0 1", ov64, rdy64); end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        n_cmp++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got v=%b want 0", ov64); end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, $urandom(), 3'd3, 1'b0, 1'b0);
        cycle(1'b1, $urandom(), 3'd4, 1'b0, 1'b0);
        n_cmp++; if (rdy64 !== 1'b0) begin n_fail++; $display("FAIL mid_full: got rdy=%b want 0", rdy64); end
        reset = 1'b1;
        #2;
        n_cmp++; if (ov64 !== 1'b0 || rdy64 !== 1'b1 || om64 !== 64'h0 || ov32 !== 1'b0 || om32 !== 32'h0) begin n_fail++; $display("FAIL mid_reset: got v=%b rdy=%b imm=%h want 0 1 0", ov64, rdy64, om64); end
        mq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        n_cmp++; if (ov64 !== 1'b0 || rdy64 !== 1'b1) begin n_fail++; $display("FAIL mid_after: got v=%b rdy=%b want 0 1", ov64, rdy64); end
    endtask

    task automatic test_random();
        ent_t        e;
        logic [63:0] x64, x32w;
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, $urandom(), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            n_cmp++; if (rdy64 !== (mq.size() < 2) || rdy32 !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b/%b want %b", k, rdy64, rdy32, mq.size() < 2); end
            n_cmp++; if (ov64 !== (mq.size() > 0) || ov32 !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b", k, ov64, ov32, mq.size() > 0); end
            if (mq.size() > 0) begin
                e = mq[0];
                x64 = ref_imm(e.instr, e.sel, 64);
                x32w = ref_imm(e.instr, e.sel, 32);
                n_cmp++; if (oi64 !== e.instr || oi32 !== e.instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h/%h want %h", k, oi64, oi32, e.instr); end
                n_cmp++; if (om64 !== x64) begin n_fail++; $display("FAIL rnd_imm64[%0d]: sel %0d got %h want %h", k, e.sel, om64, x64); end
                n_cmp++; if (om32 !== x32w[31:0]) begin n_fail++; $display("FAIL rnd_imm32[%0d]: sel %0d got %h want %h", k, e.sel, om32, x32w[31:0]); end
            end
        end
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int   outs;
        ent_t e;
        outs = 0;
        for (int k = 0; k <= 100; k++) begin
            if (k < 100) begin
                n_cmp++; if (rdy64 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, rdy64); end
            end
            if (ov64 === 1'b1 && out_ready === 1'b1) begin
                outs++;
                if (mq.size() > 0) begin
                    e = mq[0];
                    n_cmp++; if (oi64 !== e.instr) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", k, oi64, e.instr); end
                end else begin
                    n_cmp++; n_fail++; $display("FAIL b2b_extra[%0d]: got output %h want none", k, oi64);
                end
            end
            cycle(k < 100, $urandom(), 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        end
        n_cmp++; if (outs !== 100) begin n_fail++; $display("FAIL b2b_count: got %0d want 100", outs); end
        n_cmp++; if (ov64 !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got v=%b want 0", ov64); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_imm_sel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_formats();
        test_xlen32();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
